dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have no parameters: 8 blocks, 4 bytes per block, direct-mapped, write-back, write-allocate.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ADDRESS  input  8  CPU byte address; tag [7:5], index [4:2], offset [1:0].
REQ-005 SHALL have port WRITEDATA  input  8  CPU store data.
REQ-006 SHALL have port READ  input  1  CPU load request.
REQ-007 SHALL have port WRITE  input  1  CPU store request.
REQ-008 SHALL have port READDATA  output  8  load data returned to the CPU register-file write path.
REQ-009 SHALL have port BUSYWAIT  output  1  CPU stall; high while the request is not yet complete.
REQ-010 SHALL have port MEM_READ  output  1  block fetch request to data memory.
REQ-011 SHALL have port MEM_WRITE  output  1  block write-back request to data memory.
REQ-012 SHALL have port MEM_ADDRESS  output  6  block address {tag,index}.
REQ-013 SHALL have port MEM_WRITEDATA  output  32  write-back block; byte n at bits [8n+7:8n].
REQ-014 SHALL have port MEM_READDATA  input  32  fetched block, same byte order.
REQ-015 SHALL have port MEM_BUSYWAIT  input  1  memory busy.

Function
REQ-016 SHALL treat hit as: valid[index] and tag[index]==ADDRESS[7:5].
REQ-017 SHALL drive READDATA combinationally with byte offset of data[index], whatever the hit status.
REQ-018 SHALL drive BUSYWAIT = (READ|WRITE) and not (state==IDLE and hit), combinationally; a hit completes with zero stall cycles.
REQ-019 SHALL, on a write hit in IDLE, update the addressed byte and set dirty[index] at the next rising edge.
REQ-020 SHALL, when READ and WRITE are both high, treat the access as a write.
REQ-021 SHALL implement states IDLE, WRITEBACK, FETCH, UPDATE.
REQ-022 SHALL: IDLE with access and miss -> WRITEBACK if valid and dirty, else -> FETCH.
REQ-023 SHALL in WRITEBACK drive MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index].
REQ-024 SHALL in FETCH drive MEM_READ=1 and MEM_ADDRESS=ADDRESS[7:2].
REQ-025 SHALL leave WRITEBACK (-> FETCH) or FETCH (-> UPDATE) at the first rising edge at which MEM_BUSYWAIT is low, provided MEM_BUSYWAIT was sampled high at least once in that state; a per-state seen_busy flag SHALL track this and clear on every state change.
REQ-026 SHALL in UPDATE load data[index]=MEM_READDATA captured at FETCH exit, tag[index]=ADDRESS[7:5], valid=1, dirty=0, then -> IDLE; the access then hits.
REQ-027 SHALL decode MEM_READ and MEM_WRITE from state only (Moore); both 0 in IDLE and UPDATE and never high together.
REQ-028 SHALL drive MEM_ADDRESS and MEM_WRITEDATA to 0 in IDLE and UPDATE.
REQ-029 SHALL require that the CPU hold ADDRESS, WRITEDATA, READ and WRITE stable while BUSYWAIT is high; the block need not check this.
REQ-030 SHALL perform no cache or memory action when READ and WRITE are both low in IDLE.

Reset
REQ-031 SHALL, at a rising edge with RESET high, force state=IDLE, clear seen_busy, clear all valid, dirty, tag and data bits; READDATA then reads 8'h00.
REQ-032 SHALL, when RESET is asserted in WRITEBACK, FETCH or UPDATE, abandon the transfer, leave no partial block update, and drop MEM_READ/MEM_WRITE from the cycle after the reset edge.
REQ-033 SHALL treat RESET as taking priority over every other state update on the same edge.

Verification
REQ-034 SHALL pass: after reset, READ ADDRESS=8'h25, memory block 6'h09=32'hDDCCBBAA, memory busy 5 cycles -> FETCH with MEM_ADDRESS=6'h09, UPDATE, then BUSYWAIT low and READDATA=8'hBB.
REQ-035 SHALL pass: then WRITE 8'h5A to 8'h26 -> BUSYWAIT low the whole cycle, no MEM_* activity; READ 8'h26 returns 8'h5A.
REQ-036 SHALL pass: then READ 8'hC4 (same index 1, tag 6) -> WRITEBACK with MEM_ADDRESS=6'h09 and MEM_WRITEDATA=32'hDD5ABBAA, then FETCH with MEM_ADDRESS=6'h31.
REQ-037 SHALL pass: clean miss on a valid block -> direct IDLE->FETCH with MEM_WRITE never asserted.
REQ-038 SHALL pass: RESET pulsed during FETCH with memory still busy -> MEM_READ low the next cycle, state IDLE, READ of the prior address misses again.
REQ-039 SHALL pass: MEM_BUSYWAIT held low through the first cycle of FETCH -> the block stays in FETCH until busy has been seen high and then low.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: 8 blocks of 4 bytes.
// Latency: hits complete in the cycle they are presented (zero stall); misses
//          take at least one write-back (if dirty) and one fetch memory transfer plus one fill cycle.
// Backpressure: BUSYWAIT stalls the CPU until the access hits; MEM_BUSYWAIT
//               holds the cache in WRITEBACK/FETCH.
//
// Ports:
//   CLK, RESET            - single clock, synchronous active-high reset
//   ADDRESS[7:0]          - CPU byte address: tag [7:5], index [4:2], offset [1:0]
//   WRITEDATA, READ, WRITE- CPU store data and request strobes (WRITE wins if both high)
//   READDATA, BUSYWAIT    - load byte (always the indexed block) and CPU stall
//   MEM_READ, MEM_WRITE   - block fetch / write-back requests (decoded from state only)
//   MEM_ADDRESS[5:0]      - block address {tag,index}
//   MEM_WRITEDATA[31:0]   - write-back block, byte n at [8n+7:8n]
//   MEM_READDATA[31:0]    - fetched block, same byte order
//   MEM_BUSYWAIT          - memory busy
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    input  logic        READ,
    input  logic        WRITE,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Cache storage, packed so the whole array clears in one reset assignment.
    logic [7:0]        valid_q;
    logic [7:0]        dirty_q;
    logic [7:0][2:0]   tag_q;
    logic [7:0][31:0]  data_q;

    // Block captured when FETCH completes; written into the array in UPDATE.
    logic [31:0]       fill_q;
    // Set once MEM_BUSYWAIT has been sampled high in the current transfer state,
    // so a memory that is slow to raise busy is not mistaken for a finished one.
    logic              seen_busy_q;

    logic [2:0] idx;
    logic [2:0] tag_in;
    logic [4:0] byte_sel;
    logic       hit;
    logic       access;
    logic       xfer_done;

    assign idx      = ADDRESS[4:2];
    assign tag_in   = ADDRESS[7:5];
    assign byte_sel = {ADDRESS[1:0], 3'b000};
    assign hit      = valid_q[idx] && (tag_q[idx] == tag_in);
    assign access   = READ || WRITE;
    assign xfer_done = seen_busy_q && !MEM_BUSYWAIT;

    // Load path reads the indexed block regardless of hit; the CPU only
    // consumes it once BUSYWAIT drops.
    assign READDATA = data_q[idx][byte_sel +: 8];
    assign BUSYWAIT = access && !((state == IDLE) && hit);

    // Next-state and Moore memory-side outputs.
    always_comb begin
        state_nxt     = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (state)
            IDLE: begin
                if (access && !hit) begin
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_nxt = WRITEBACK;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = data_q[idx];
                if (xfer_done) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
                if (xfer_done) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and cache arrays; reset wins over every other update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            seen_busy_q <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            fill_q      <= '0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                seen_busy_q <= 1'b0;
            end else if (((state == WRITEBACK) || (state == FETCH)) && MEM_BUSYWAIT) begin
                seen_busy_q <= 1'b1;
            end

            // Store hit: WRITE covers the READ+WRITE case as a store.
            if ((state == IDLE) && WRITE && hit) begin
                data_q[idx][byte_sel +: 8] <= WRITEDATA;
                dirty_q[idx]               <= 1'b1;
            end

            if ((state == FETCH) && xfer_done) begin
                fill_q <= MEM_READDATA;
            end

            if (state == UPDATE) begin
                data_q[idx]  <= fill_q;
                tag_q[idx]   <= tag_in;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios with literal expectations
// followed by randomized CPU traffic against a behavioural model and a
// byte-level view of memory as the CPU should see it.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic        READ;
    logic        WRITE;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'd0;
    logic        MEM_BUSYWAIT = 1'b0;

    always #5 CLK = ~CLK;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READ          (READ),
        .WRITE         (WRITE),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Data memory: block-level store with configurable start delay (busy
    // stays low) and busy duration. Reset aborts any transfer in progress.
    // ------------------------------------------------------------------
    logic [31:0] mem [64];
    int          mst = 0;
    int          mcnt, mdcnt, mlat, mdly;
    int          lat_cfg = 2;
    int          dly_cfg = 0;
    bit          rand_mem = 1'b0;
    logic        mop_wr;
    logic [5:0]  maddr;
    logic [31:0] mwdata;

    always @(posedge CLK) begin
        if (RESET) begin
            mst = 0;
            MEM_BUSYWAIT <= 1'b0;
        end else begin
            case (mst)
                0: if (MEM_READ || MEM_WRITE) begin
                    mop_wr = MEM_WRITE;
                    maddr  = MEM_ADDRESS;
                    mwdata = MEM_WRITEDATA;
                    mlat   = rand_mem ? int'($urandom_range(1, 4)) : lat_cfg;
                    mdly   = rand_mem ? int'($urandom_range(0, 2)) : dly_cfg;
                    if (mdly == 0) begin
                        MEM_BUSYWAIT <= 1'b1;
                        mcnt = mlat;
                        mst  = 2;
                    end else begin
                        mdcnt = mdly;
                        mst   = 1;
                    end
                end
                1: if (mdcnt == 1) begin
                    MEM_BUSYWAIT <= 1'b1;
                    mcnt = mlat;
                    mst  = 2;
                end else begin
                    mdcnt--;
                end
                2: if (mcnt == 1) begin
                    MEM_BUSYWAIT <= 1'b0;
                    if (mop_wr) mem[maddr] = mwdata;
                    else        MEM_READDATA <= mem[maddr];
                    mst = 3;
                end else begin
                    mcnt--;
                end
                default: mst = 0;  // completion edge: the request is still visible, ignore it
            endcase
        end
    end

    // Byte view of memory as the CPU should observe it.
    logic [7:0] golden [256];

    function automatic void rebuild_golden();
        for (int a = 0; a < 256; a++) begin
            logic [31:0] w;
            w = mem[a >> 2];
            golden[a] = w[(a % 4) * 8 +: 8];
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: cache contents plus a queue of outstanding block
    // transfers for the current miss (1 = write-back, 2 = fetch, 3 = fill).
    // A transfer ends at the first edge with memory idle after it was seen busy.
    // ------------------------------------------------------------------
    logic [7:0]  m_valid = '0;
    logic [7:0]  m_dirty = '0;
    logic [2:0]  m_tag  [8];
    logic [31:0] m_data [8];
    int          xfers [$];
    bit          m_seen;
    logic [31:0] m_buf;
    logic [2:0]  mi, mt;
    logic [1:0]  mo;

    always @(posedge CLK) begin
        mi = ADDRESS[4:2];
        mt = ADDRESS[7:5];
        mo = ADDRESS[1:0];
        if (RESET) begin
            m_valid = '0;
            m_dirty = '0;
            for (int k = 0; k < 8; k++) begin
                m_tag[k]  = '0;
                m_data[k] = '0;
            end
            xfers.delete();
            m_seen = 1'b0;
        end else if (xfers.size() == 0) begin
            if (READ || WRITE) begin
                if (m_valid[mi] && m_tag[mi] == mt) begin
                    if (WRITE) begin
                        m_data[mi][{mo, 3'b000} +: 8] = WRITEDATA;
                        m_dirty[mi] = 1'b1;
                    end
                end else begin
                    if (m_valid[mi] && m_dirty[mi]) xfers.push_back(1);
                    xfers.push_back(2);
                    xfers.push_back(3);
                    m_seen = 1'b0;
                end
            end
        end else if (xfers[0] == 3) begin
            m_data[mi]  = m_buf;
            m_tag[mi]   = mt;
            m_valid[mi] = 1'b1;
            m_dirty[mi] = 1'b0;
            void'(xfers.pop_front());
        end else begin
            if (m_seen && !MEM_BUSYWAIT) begin
                if (xfers[0] == 2) m_buf = MEM_READDATA;
                void'(xfers.pop_front());
                m_seen = 1'b0;
            end else if (MEM_BUSYWAIT) begin
                m_seen = 1'b1;
            end
        end
    end

    // Single compare process: every cycle once checking is enabled.
    bit         chk_en = 1'b0;
    logic [2:0] ci, ct;
    logic [1:0] co;
    int         cur;
    bit         exp_hit, exp_busy;

    always @(negedge CLK) begin
        if (chk_en) begin
            ci  = ADDRESS[4:2];
            ct  = ADDRESS[7:5];
            co  = ADDRESS[1:0];
            cur = (xfers.size() != 0) ? xfers[0] : 0;
            exp_hit  = m_valid[ci] && (m_tag[ci] == ct);
            exp_busy = (READ || WRITE) && !(cur == 0 && exp_hit);
            chk("busywait", 32'(BUSYWAIT), 32'(exp_busy));
            chk("readdata", 32'(READDATA), 32'(m_data[ci][{co, 3'b000} +: 8]));
            chk("mem_read", 32'(MEM_READ), 32'(cur == 2));
            chk("mem_write", 32'(MEM_WRITE), 32'(cur == 1));
            chk("mem_address", 32'(MEM_ADDRESS),
                (cur == 1) ? 32'({m_tag[ci], ci}) : (cur == 2) ? 32'(ADDRESS[7:2]) : 32'd0);
            chk("mem_writedata", MEM_WRITEDATA, (cur == 1) ? m_data[ci] : 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // CPU side
    // ------------------------------------------------------------------
    int          stall, rd_cycles;
    bit          saw_rd, saw_wr;
    logic [5:0]  rd_addr, wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  last_rd;

    task automatic access(input logic [7:0] a, input bit rd, input bit wr, input logic [7:0] wd);
        bit done;
        ADDRESS   = a;
        READ      = rd;
        WRITE     = wr;
        WRITEDATA = wd;
        stall = 0; rd_cycles = 0; saw_rd = 0; saw_wr = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                if (!saw_rd) rd_addr = MEM_ADDRESS;
                saw_rd = 1;
                rd_cycles++;
            end
            if (MEM_WRITE) begin
                if (!saw_wr) begin
                    wb_addr = MEM_ADDRESS;
                    wb_data = MEM_WRITEDATA;
                end
                saw_wr = 1;
            end
            if (!BUSYWAIT) done = 1;
            else stall++;
        end
        chk("access_done", 32'(done), 32'd1);
        if (done) begin
            last_rd = READDATA;
            if (wr) golden[a] = wd;
            else chk("load_value", 32'(READDATA), 32'(golden[a]));
        end
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        rebuild_golden();
    endtask

    initial begin
        bit seen;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h25; WRITEDATA = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[6'h09] = 32'hDDCCBBAA;
        rebuild_golden();
        repeat (2) @(posedge CLK);
        #1;
        RESET  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge CLK);
        chk("rst_readdata", 32'(READDATA), 32'h00);
        chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
        chk("rst_mem_req", 32'({MEM_READ, MEM_WRITE}), 32'd0);
        @(posedge CLK);
        #1;

        // Cold read miss, memory busy 5 cycles
        lat_cfg = 5; dly_cfg = 0;
        access(8'h25, 1, 0, 8'h00);
        chk("cold_fetch_addr", 32'(rd_addr), 32'h09);
        chk("cold_readdata", 32'(last_rd), 32'hBB);
        chk("cold_no_wb", 32'(saw_wr), 32'd0);
        chk("cold_stall", 32'(stall), 32'd9);

        // Write hit then read it back
        lat_cfg = 2;
        access(8'h26, 0, 1, 8'h5A);
        chk("wr_hit_stall", 32'(stall), 32'd0);
        chk("wr_hit_no_mem", 32'({saw_rd, saw_wr}), 32'd0);
        access(8'h26, 1, 0, 8'h00);
        chk("rd_after_wr", 32'(last_rd), 32'h5A);

        // Dirty conflict: write-back then fetch
        access(8'hC4, 1, 0, 8'h00);
        chk("wb_addr", 32'(wb_addr), 32'h09);
        chk("wb_data", wb_data, 32'hDD5ABBAA);
        chk("conflict_fetch_addr", 32'(rd_addr), 32'h31);

        // Clean conflict: straight to fetch
        access(8'h24, 1, 0, 8'h00);
        chk("clean_no_wb", 32'(saw_wr), 32'd0);
        chk("clean_fetch", 32'(saw_rd), 32'd1);
        chk("clean_readdata", 32'(last_rd), 32'hAA);

        // Reset during FETCH with memory busy
        lat_cfg = 8;
        ADDRESS = 8'h44; READ = 1'b1;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge CLK);
            if (MEM_BUSYWAIT) seen = 1;
        end
        chk("busy_before_reset", 32'(seen), 32'd1);
        @(posedge CLK);
        #1;
        do_reset();
        @(negedge CLK);
        chk("post_rst_mem_read", 32'(MEM_READ), 32'd0);
        chk("post_rst_mem_write", 32'(MEM_WRITE), 32'd0);
        @(posedge CLK);
        #1;
        lat_cfg = 2;
        access(8'h44, 1, 0, 8'h00);
        chk("post_rst_misses", 32'(saw_rd), 32'd1);

        // Memory slow to raise busy: FETCH must wait for busy high then low
        lat_cfg = 1; dly_cfg = 2;
        access(8'h84, 1, 0, 8'h00);
        chk("late_busy_fetch_cycles", 32'(rd_cycles), 32'd5);
        chk("late_busy_stall", 32'(stall), 32'd7);

        // Randomized traffic
        rand_mem = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            int op;
            a  = 8'($urandom_range(0, 127));
            op = int'($urandom_range(0, 7));
            access(a, op < 4 || op == 7, op >= 4, 8'($urandom));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
